multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS32 core. It replaces the purely combinational opcode decoder with a Moore-style finite state machine (FSM). The FSM steps each instruction through fetch, decode, execute, memory and writeback phases over a shared ALU and a unified instruction/data memory. It drives every datapath mux select, enable and ALU operation, and handshakes with memory through `mem_ready`. It supports the opcodes R-type, lw, sw, beq, addi and j.

## Interface
Parameters:
- `MAX_WAIT`, default 15: memory wait-cycle limit before timeout. Used only with `MCCTRL_MEM_WAIT_EN`.
- `WAIT_W`, default 4: wait counter width. Must satisfy 2^`WAIT_W` > `MAX_WAIT`.

Ports:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 6: instruction register bits [31:26]. Valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero (beq).
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: write register select, 1 = rd, 0 = rt.
- `mem_to_reg` out 1: writeback data select, 1 = MDR, 0 = ALUOut.
- `reg_write` out 1: register file write.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select, 00 = rt, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode funct.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` out 1: registered one-cycle pulse after DECODE sees an unsupported opcode.
- `mem_timeout` out 1: registered one-cycle pulse on a memory timeout.
- `state` out 4: current state, for debug.

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge.

Outputs are decoded from `state` only. The exceptions are the `mem_ready` gating in FETCH and the `instr_done` term in MEMWR. Any output not listed for a state is 0.

- FETCH: `mem_read`=1, `alu_src_b`=01. `ir_write` and `pc_write` equal `mem_ready`. Go to DECODE when `mem_ready`=1, otherwise stay.
- DECODE: `alu_src_b`=11 (precomputes the branch target). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → FETCH, with `instr_done`=1 and `illegal_op` pulsed next cycle.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1. Go to MEMWB on `mem_ready`.
- MEMWB: `mem_to_reg`=1, `reg_write`=1. Go to FETCH.
- MEMWR: `iord`=1, `mem_write`=1, `instr_done`=`mem_ready`. Go to FETCH on `mem_ready`.
- EXEC: `alu_src_a`=1, `alu_op`=10. Go to ALUWB.
- ALUWB: `reg_dst`=1, `reg_write`=1. Go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_source`=01, `pc_write_cond`=1. Go to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. Go to ADDIWB.
- ADDIWB: `reg_write`=1. Go to FETCH.
- JUMP: `pc_source`=10, `pc_write`=1. Go to FETCH.
- `instr_done` is also 1 in MEMWB, ALUWB, BRANCH, ADDIWB and JUMP.

## Timing
- Reset values: `state`=FETCH, `illegal_op`=0, `mem_timeout`=0, wait counter=0.
- While `rst_n`=0: `mem_read`, `mem_write`, `pc_write`, `ir_write` and `reg_write` are forced to 0.
- Reset asserted mid-instruction abandons it immediately. No write occurs in that cycle or afterwards.
- `opcode` is sampled only in DECODE. Changes in other states have no effect.
- Latency in cycles, with zero memory wait:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal opcode 2
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` in any non-memory state is ignored.

## Configuration
Macro `MCCTRL_MEM_WAIT_EN`.

Defined:
- FETCH, MEMRD and MEMWR wait on `mem_ready` as described above.
- A wait counter increments on each cycle of such a stall and clears on every state change.
- If the counter equals `MAX_WAIT` and `mem_ready`=0, the next state is FETCH and `mem_timeout` pulses.
- On timeout there is no `reg_write`, `ir_write` or `pc_write`, so the fetch is retried at the same PC.
- `mem_ready`=1 in the limit cycle wins; no timeout occurs.

Undefined:
- `mem_ready` is treated as constant 1, so every memory state lasts one cycle.
- No counter exists, `mem_timeout` is tied to 0, and `MAX_WAIT` is unused.

## Test plan
- Reset, then `opcode`=000000 with `mem_ready`=1: states 0,1,6,7,0. ALUWB shows `reg_dst`=1 and `reg_write`=1. `instr_done` pulses once.
- lw (100011) with `mem_ready` held low 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. Total 7 cycles. `reg_write` is high only in MEMWB.
- beq (000100): BRANCH shows `alu_op`=01, `pc_source`=01, `pc_write_cond`=1. j (000010): JUMP shows `pc_source`=10, `pc_write`=1.
- `opcode`=111111: states 0,1,0. `illegal_op` is 1 for exactly one cycle. `reg_write` and `mem_write` are never 1.
- `rst_n` low during MEMWR of sw: `mem_write` drops asynchronously and `state` returns to 0. After release, FETCH resumes.
- `MCCTRL_MEM_WAIT_EN` defined, `MAX_WAIT`=3, `mem_ready` stuck at 0 in FETCH: after 4 FETCH cycles `mem_timeout` pulses, `pc_write` and `ir_write` are never 1, and `state` stays 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the MIPS32 datapath/memory (slave).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_timeout, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing MIPS32 instructions (R-type, lw, sw, beq, addi, j) over a shared ALU/memory.
// Optional memory stall/timeout handling is enabled by defining MCCTRL_MEM_WAIT_EN.
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_is_sw;
  logic       r_illegal;
  logic       w_illegal;
  logic       w_mem_rdy;
  logic       w_timeout;
  logic       w_pc_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;

`ifdef MCCTRL_MEM_WAIT_EN
  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout;
  logic              w_stall;

  assign w_mem_rdy = bus.mem_ready;
  assign w_stall   = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                     && !w_mem_rdy;
  assign w_timeout = w_stall && (r_wait == WAIT_W'(MAX_WAIT));

  // Timeout restarts from FETCH, so the counter must clear even when FETCH stays FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_timeout || (w_next != r_state)) begin
        r_wait <= '0;
      end else if (w_stall) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign bus.mem_timeout = r_timeout;
`else
  logic [WAIT_W:0] w_unused;

  assign w_mem_rdy       = 1'b1;
  assign w_timeout       = 1'b0;
  assign w_unused        = {bus.mem_ready, WAIT_W'(MAX_WAIT)};
  assign bus.mem_timeout = 1'b0;
`endif

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: w_next = r_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next = S_FETCH;
    end
  end

  // lw/sw choice is latched in DECODE so later opcode changes cannot redirect MEMADR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_is_sw   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
      if (r_state == S_DECODE) begin
        r_is_sw <= (bus.opcode == OP_SW);
      end
    end
  end

  always_comb begin
    w_pc_write         = 1'b0;
    w_mem_read         = 1'b0;
    w_mem_write        = 1'b0;
    w_ir_write         = 1'b0;
    w_reg_write        = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.iord           = 1'b0;
    bus.reg_dst        = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = 2'b00;
    bus.alu_op         = 2'b00;
    bus.pc_source      = 2'b00;
    bus.instr_done     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read    = 1'b1;
        bus.alu_src_b = 2'b01;
        w_ir_write    = w_mem_rdy;
        w_pc_write    = w_mem_rdy;
      end
      S_DECODE: begin
        bus.alu_src_b  = 2'b11;
        bus.instr_done = w_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.iord   = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        w_reg_write    = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.iord       = 1'b1;
        w_mem_write    = 1'b1;
        bus.instr_done = w_mem_rdy;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        bus.reg_dst    = 1'b1;
        w_reg_write    = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_source     = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.instr_done    = 1'b1;
      end
      S_ADDIWB: begin
        w_reg_write    = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_source  = 2'b10;
        w_pc_write     = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory requests and architectural writes are killed combinationally while in reset.
  assign bus.pc_write   = w_pc_write  & rst_n;
  assign bus.mem_read   = w_mem_read  & rst_n;
  assign bus.mem_write  = w_mem_write & rst_n;
  assign bus.ir_write   = w_ir_write  & rst_n;
  assign bus.reg_write  = w_reg_write & rst_n;
  assign bus.illegal_op = r_illegal;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus hand sequences for reset and memory stalls.
module tb_multicycle_control;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multicycle_control_if bus ();

  multicycle_control #(
    .MAX_WAIT (3),
    .WAIT_W   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
  // mem_to_reg, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], instr_done
  localparam logic [16:0] C_RST     = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FSTALL  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DECILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
  localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
  localparam logic [16:0] C_MWSTALL = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_ALUWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
  localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
  localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;
  localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000;
  localparam logic [5:0] JJ = 6'b000010;
  localparam logic [5:0] IL = 6'b111111;

  typedef struct {
    bit          rst;
    logic [5:0]  opc;
    bit          rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    bit          ill;
    bit          tmo;
    string       name;
  } vec_t;

  vec_t vecs[$];

  logic [16:0] w_ctl;
  assign w_ctl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                  bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done};

  task automatic check(input string nm, input logic [3:0] est, input logic [16:0] ectl,
                       input bit eill, input bit etmo);
    n_checks++;
    if (bus.state !== est || w_ctl !== ectl || bus.illegal_op !== eill ||
        bus.mem_timeout !== etmo) begin
      n_fail++;
      $display("FAIL %s: got st=%0d ctl=%b ill=%b tmo=%b, expected st=%0d ctl=%b ill=%b tmo=%b",
               nm, bus.state, w_ctl, bus.illegal_op, bus.mem_timeout, est, ectl, eill, etmo);
    end
  endtask

  task automatic step(input bit rst, input logic [5:0] opc, input bit rdy, input logic [3:0] est,
                      input logic [16:0] ectl, input bit eill, input bit etmo, input string nm);
    @(negedge clk);
    rst_n         = rst;
    bus.opcode    = opc;
    bus.mem_ready = rdy;
    #1;
    check(nm, est, ectl, eill, etmo);
  endtask

  function automatic void add(input bit rst, input logic [5:0] opc, input bit rdy,
                              input logic [3:0] st, input logic [16:0] ctl, input bit ill,
                              input string nm);
    vec_t v;
    v.rst = rst; v.opc = opc; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ill = ill; v.tmo = 1'b0;
    v.name = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.opcode    = RT;
    bus.mem_ready = 1'b1;

    add(0, RT, 1, 0, C_RST,    0, "reset");
    add(1, RT, 1, 0, C_FETCH,  0, "rt_fetch");
    add(1, RT, 1, 1, C_DEC,    0, "rt_decode");
    add(1, RT, 1, 6, C_EXEC,   0, "rt_exec");
    add(1, RT, 1, 7, C_ALUWB,  0, "rt_aluwb");
    add(1, LW, 1, 0, C_FETCH,  0, "lw_fetch");
    add(1, LW, 1, 1, C_DEC,    0, "lw_decode");
    add(1, LW, 1, 2, C_MEMADR, 0, "lw_memadr");
    add(1, LW, 1, 3, C_MEMRD,  0, "lw_memrd");
    add(1, LW, 1, 4, C_MEMWB,  0, "lw_memwb");
    add(1, SW, 1, 0, C_FETCH,  0, "sw_fetch");
    add(1, SW, 1, 1, C_DEC,    0, "sw_decode");
    add(1, SW, 1, 2, C_MEMADR, 0, "sw_memadr");
    add(1, SW, 1, 5, C_MEMWR,  0, "sw_memwr");
    add(1, BQ, 1, 0, C_FETCH,  0, "beq_fetch");
    add(1, BQ, 1, 1, C_DEC,    0, "beq_decode");
    add(1, BQ, 1, 8, C_BRANCH, 0, "beq_branch");
    add(1, AI, 1, 0, C_FETCH,  0, "addi_fetch");
    add(1, AI, 1, 1, C_DEC,    0, "addi_decode");
    add(1, AI, 1, 9, C_MEMADR, 0, "addi_exec");
    add(1, AI, 1, 10, C_ADDIWB, 0, "addi_wb");
    add(1, JJ, 1, 0, C_FETCH,  0, "j_fetch");
    add(1, JJ, 1, 1, C_DEC,    0, "j_decode");
    add(1, JJ, 1, 11, C_JUMP,  0, "j_jump");
    add(1, IL, 1, 0, C_FETCH,  0, "ill_fetch");
    add(1, IL, 1, 1, C_DECILL, 0, "ill_decode");
    add(1, IL, 1, 0, C_FETCH,  1, "ill_pulse");
    add(1, RT, 1, 1, C_DEC,    0, "ill_pulse_end");
    add(1, LW, 1, 6, C_EXEC,   0, "opc_ignored_exec");
    add(1, LW, 1, 7, C_ALUWB,  0, "opc_ignored_aluwb");
    add(1, LW, 1, 0, C_FETCH,  0, "lw2_fetch");
    add(1, LW, 1, 1, C_DEC,    0, "lw2_decode");
    add(1, SW, 1, 2, C_MEMADR, 0, "lw2_memadr_opc_sw");
    add(1, SW, 1, 3, C_MEMRD,  0, "lw2_stays_read");
    add(1, SW, 1, 4, C_MEMWB,  0, "lw2_memwb");
    add(1, SW, 1, 0, C_FETCH,  0, "lw2_done");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].opc, vecs[i].rdy, vecs[i].st, vecs[i].ctl, vecs[i].ill,
           vecs[i].tmo, vecs[i].name);
    end

    // Asynchronous reset in the middle of a store's MEMWR cycle.
    step(0, SW, 1, 0, C_RST,    0, 0, "a_reset");
    step(1, SW, 1, 0, C_FETCH,  0, 0, "a_fetch");
    step(1, SW, 1, 1, C_DEC,    0, 0, "a_decode");
    step(1, SW, 1, 2, C_MEMADR, 0, 0, "a_memadr");
    step(1, SW, 1, 5, C_MEMWR,  0, 0, "a_memwr");
    #2;
    rst_n = 1'b0;
    #1;
    check("a_async_drop", 0, C_RST, 0, 0);
    step(0, RT, 1, 0, C_RST,    0, 0, "a_held");
    step(1, RT, 1, 0, C_FETCH,  0, 0, "a_resume");
    step(1, RT, 1, 1, C_DEC,    0, 0, "a_resume_decode");

    // lw with memory not ready in MEMRD.
    step(0, LW, 1, 0, C_RST,    0, 0, "b_reset");
    step(1, LW, 1, 0, C_FETCH,  0, 0, "b_fetch");
    step(1, LW, 1, 1, C_DEC,    0, 0, "b_decode");
    step(1, LW, 1, 2, C_MEMADR, 0, 0, "b_memadr");
`ifdef MCCTRL_MEM_WAIT_EN
    step(1, LW, 0, 3, C_MEMRD,  0, 0, "b_memrd_wait1");
    step(1, LW, 0, 3, C_MEMRD,  0, 0, "b_memrd_wait2");
    step(1, LW, 1, 3, C_MEMRD,  0, 0, "b_memrd_ready");
`else
    step(1, LW, 0, 3, C_MEMRD,  0, 0, "b_memrd_rdy_ignored");
`endif
    step(1, LW, 1, 4, C_MEMWB,  0, 0, "b_memwb");
    step(1, LW, 1, 0, C_FETCH,  0, 0, "b_done");

    // FETCH with memory stuck not ready.
    step(0, RT, 0, 0, C_RST,    0, 0, "c_reset");
`ifdef MCCTRL_MEM_WAIT_EN
    for (int k = 0; k < 4; k++) begin
      step(1, RT, 0, 0, C_FSTALL, 0, 0, "c_fetch_stall");
    end
    step(1, RT, 0, 0, C_FSTALL, 0, 1, "c_timeout_pulse");
    step(1, RT, 0, 0, C_FSTALL, 0, 0, "c_timeout_end");
    step(1, RT, 1, 0, C_FETCH,  0, 0, "c_retry_fetch");
    step(1, RT, 1, 1, C_DEC,    0, 0, "c_retry_decode");

    // Store whose memory answers exactly in the limit cycle: no timeout.
    step(0, SW, 1, 0, C_RST,     0, 0, "d_reset");
    step(1, SW, 1, 0, C_FETCH,   0, 0, "d_fetch");
    step(1, SW, 1, 1, C_DEC,     0, 0, "d_decode");
    step(1, SW, 1, 2, C_MEMADR,  0, 0, "d_memadr");
    for (int k = 0; k < 3; k++) begin
      step(1, SW, 0, 5, C_MWSTALL, 0, 0, "d_memwr_stall");
    end
    step(1, SW, 1, 5, C_MEMWR,   0, 0, "d_memwr_limit_ready");
    step(1, SW, 1, 0, C_FETCH,   0, 0, "d_no_timeout");
`else
    step(1, RT, 0, 0, C_FETCH,  0, 0, "c_fetch_rdy_ignored");
    step(1, RT, 0, 1, C_DEC,    0, 0, "c_decode");
    step(1, RT, 0, 6, C_EXEC,   0, 0, "c_exec");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
